// File: rtl/key_match_checker.sv
`default_nettype none
// key_match_checker: synchronizes and debounces note/octave keys, then tracks
// whether the player hit the expected note, scoring hits and counting timeouts. Rev 1.0
module key_match_checker #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear_score,
    input  logic [6:0] exp_note,
    input  logic       exp_high,
    input  logic       exp_low,
    input  logic [6:0] keys,
    input  logic       oct_up,
    input  logic       oct_down,
    output logic       is_match,
    output logic [7:0] score,
    output logic [7:0] miss_cnt,
    output logic [1:0] state
);
    localparam int NIN = 9;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMW-1:0] TM_LAST = TMW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HIT  = 2'd2,
        S_MISS = 2'd3
    } state_t;

    logic [NIN-1:0] raw_in;
    logic [NIN-1:0] sync1_q, sync2_q;
    logic [NIN-1:0] deb_q, deb_d;
    logic [DBW-1:0] dbc_q [NIN];
    logic [DBW-1:0] dbc_d [NIN];
    logic [NIN-1:0] note_q, note_now;
    state_t         state_q, state_d;
    logic [TMW-1:0] tmr_q, tmr_d;
    logic           scored_q, scored_d;
    logic           is_match_q, is_match_d;
    logic [7:0]     score_q, score_d;
    logic [7:0]     miss_q, miss_d;
    logic           match, note_chg, score_inc, miss_inc;

    assign raw_in   = {keys, oct_up, oct_down};
    assign note_now = {exp_note, exp_high, exp_low};
    assign match    = (deb_q == note_now);
    assign note_chg = (note_now != note_q);

    // Each input flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NIN; i++) begin
            dbc_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dbc_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        scored_d  = scored_q;
        score_inc = 1'b0;
        miss_inc  = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_WAIT;
                    tmr_d    = '0;
                    scored_d = 1'b0;
                end
                S_WAIT: begin
                    if (note_chg) begin
                        tmr_d    = '0;
                        scored_d = 1'b0;
                    end else if (match) begin
                        state_d   = S_HIT;
                        score_inc = !scored_q;
                        scored_d  = 1'b1;
                    end else if (tmr_q == TM_LAST) begin
                        state_d  = S_MISS;
                        miss_inc = 1'b1;
                        scored_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_HIT: begin
                    if (note_chg) begin
                        state_d  = S_WAIT;
                        tmr_d    = '0;
                        scored_d = 1'b0;
                    end else if (!match) begin
                        state_d = S_WAIT;
                        tmr_d   = '0;
                    end
                end
                S_MISS: begin
                    if (note_chg) begin
                        state_d  = S_WAIT;
                        tmr_d    = '0;
                        scored_d = 1'b0;
                    end else if (match) begin
                        state_d = S_HIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        is_match_d = (state_d == S_HIT);
    end

    // Clearing wins over a same-cycle increment; both counters stick at 255.
    always_comb begin
        score_d = score_q;
        miss_d  = miss_q;
        if (clear_score) begin
            score_d = '0;
            miss_d  = '0;
        end else begin
            if (score_inc && (score_q != 8'hFF)) score_d = score_q + 8'd1;
            if (miss_inc && (miss_q != 8'hFF))   miss_d  = miss_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            for (int i = 0; i < NIN; i++) dbc_q[i] <= '0;
            note_q     <= '0;
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            scored_q   <= 1'b0;
            is_match_q <= 1'b0;
            score_q    <= '0;
            miss_q     <= '0;
        end else begin
            sync1_q    <= raw_in;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int i = 0; i < NIN; i++) dbc_q[i] <= dbc_d[i];
            note_q     <= note_now;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            scored_q   <= scored_d;
            is_match_q <= is_match_d;
            score_q    <= score_d;
            miss_q     <= miss_d;
        end
    end

    assign is_match = is_match_q;
    assign score    = score_q;
    assign miss_cnt = miss_q;
    assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_key_match_checker.sv
`default_nettype none
// tb_key_match_checker: directed scenarios plus randomized key traffic, all
// compared each cycle against a behavioural model of the note-matching rules.
module tb_key_match_checker;
    localparam int DEB    = 20;
    localparam int TMO    = 1000;
    localparam int S_IDLE = 0;
    localparam int S_WAIT = 1;
    localparam int S_HIT  = 2;
    localparam int S_MISS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       clear_score = 1'b0;
    logic [6:0] exp_note = '0;
    logic       exp_high = 1'b0;
    logic       exp_low = 1'b0;
    logic [6:0] keys = '0;
    logic       oct_up = 1'b0;
    logic       oct_down = 1'b0;
    logic       is_match;
    logic [7:0] score;
    logic [7:0] miss_cnt;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    logic [8:0] m_hist[$];
    logic [8:0] m_deb;
    logic [8:0] m_prev;
    int         m_state, m_wait, m_score, m_miss;
    bit         m_scored, m_ismatch;

    always #5 clk = ~clk;

    key_match_checker #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear_score(clear_score),
        .exp_note   (exp_note),
        .exp_high   (exp_high),
        .exp_low    (exp_low),
        .keys       (keys),
        .oct_up     (oct_up),
        .oct_down   (oct_down),
        .is_match   (is_match),
        .score      (score),
        .miss_cnt   (miss_cnt),
        .state      (state)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < DEB + 2; i++) m_hist.push_back(9'd0);
        m_deb    = '0;
        m_prev   = '0;
        m_state  = S_IDLE;
        m_wait   = 0;
        m_scored = 0;
        m_score  = 0;
        m_miss   = 0;
        m_ismatch = 0;
    endtask

    // One rising edge of the reference behaviour, using the inputs present before it.
    task automatic model_step();
        logic [8:0] want;
        logic [8:0] h;
        bit match, chg, inc_s, inc_m, all_diff;
        int ns;
        want  = {exp_note, exp_high, exp_low};
        match = (m_deb == want);
        chg   = (want != m_prev);
        inc_s = 0;
        inc_m = 0;
        ns    = m_state;
        if (!enable) begin
            ns = S_IDLE;
        end else if (m_state == S_IDLE) begin
            ns = S_WAIT; m_wait = 0; m_scored = 0;
        end else if (chg) begin
            ns = S_WAIT; m_wait = 0; m_scored = 0;
        end else if (m_state == S_WAIT) begin
            if (match) begin
                ns = S_HIT; inc_s = !m_scored; m_scored = 1;
            end else if (m_wait == TMO - 1) begin
                ns = S_MISS; inc_m = 1; m_scored = 1;
            end else begin
                m_wait++;
            end
        end else if (m_state == S_HIT) begin
            if (!match) begin ns = S_WAIT; m_wait = 0; end
        end else if (match) begin
            ns = S_HIT;
        end
        if (clear_score) begin
            m_score = 0; m_miss = 0;
        end else begin
            if (inc_s && m_score < 255) m_score++;
            if (inc_m && m_miss < 255) m_miss++;
        end
        m_state   = ns;
        m_ismatch = (ns == S_HIT);
        m_prev    = want;
        // Debounced level flips once the last DEB synchronized samples all disagree with it.
        for (int b = 0; b < 9; b++) begin
            all_diff = 1;
            for (int k = 1; k <= DEB; k++) begin
                h = m_hist[k];
                if (h[b] == m_deb[b]) all_diff = 0;
            end
            if (all_diff) m_deb[b] = ~m_deb[b];
        end
        m_hist.push_back({keys, oct_up, oct_down});
        void'(m_hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        chk_eq("state", {30'd0, state}, m_state);
        chk_eq("is_match", {31'd0, is_match}, {31'd0, m_ismatch});
        chk_eq("score", {24'd0, score}, m_score);
        chk_eq("miss_cnt", {24'd0, miss_cnt}, m_miss);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] notes [4];
        int len;
        notes[0] = 7'b0000000;
        notes[1] = 7'b1000000;
        notes[2] = 7'b0010000;
        notes[3] = 7'b0000001;
        model_reset();
        #12;
        chk_eq("rst_state", {30'd0, state}, 0);
        chk_eq("rst_match", {31'd0, is_match}, 0);
        chk_eq("rst_score", {24'd0, score}, 0);
        chk_eq("rst_miss", {24'd0, miss_cnt}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();

        // Stable correct press: hit exactly 23 cycles later, single score.
        enable = 1'b1;
        exp_note = 7'b0000100;
        repeat (5) tick();
        chk_eq("wait_state", {30'd0, state}, S_WAIT);
        keys = 7'b0000100;
        repeat (22) tick();
        chk_eq("lat_early", {31'd0, is_match}, 0);
        tick();
        chk_eq("lat_hit", {31'd0, is_match}, 1);
        chk_eq("lat_score", {24'd0, score}, 1);
        repeat (40) tick();
        chk_eq("held_score", {24'd0, score}, 1);

        // Bouncing key for 60 cycles, then stable.
        exp_note = 7'b0100000;
        for (int c = 0; c < 60; c++) begin
            keys = (((c / 5) % 2) == 0) ? 7'b0100000 : 7'b0000000;
            tick();
            chk_eq("bounce_nomatch", {31'd0, is_match}, 0);
        end
        keys = 7'b0100000;
        repeat (22) tick();
        chk_eq("bounce_early", {31'd0, is_match}, 0);
        tick();
        chk_eq("bounce_hit", {31'd0, is_match}, 1);
        chk_eq("bounce_score", {24'd0, score}, 2);

        // Timeout to MISS, then a late correct press with no score.
        exp_note = 7'b0000001;
        keys = 7'b0000000;
        repeat (TMO + 5) tick();
        chk_eq("miss_state", {30'd0, state}, S_MISS);
        chk_eq("miss_cnt1", {24'd0, miss_cnt}, 1);
        keys = 7'b0000001;
        repeat (23) tick();
        chk_eq("miss_hit", {31'd0, is_match}, 1);
        chk_eq("miss_score", {24'd0, score}, 2);

        // Octave mismatch blocks the match until oct_up follows exp_high.
        exp_note = 7'b0001000;
        exp_high = 1'b1;
        keys = 7'b0001000;
        repeat (40) tick();
        chk_eq("oct_nomatch", {31'd0, is_match}, 0);
        oct_up = 1'b1;
        repeat (23) tick();
        chk_eq("oct_hit", {31'd0, is_match}, 1);
        chk_eq("oct_score", {24'd0, score}, 3);

        // Fast alternating notes to drive the score into saturation.
        for (int n = 0; n < 260; n++) begin
            exp_note = 7'b0000010;
            tick();
            exp_note = 7'b0001000;
            tick();
            tick();
        end
        chk_eq("sat_score", {24'd0, score}, 255);
        exp_note = 7'b0000010;
        tick();
        exp_note = 7'b0001000;
        tick();
        clear_score = 1'b1;
        tick();
        clear_score = 1'b0;
        chk_eq("clr_score", {24'd0, score}, 0);
        chk_eq("clr_miss", {24'd0, miss_cnt}, 0);
        chk_eq("clr_match", {31'd0, is_match}, 1);

        // Asynchronous reset while in HIT.
        exp_note = 7'b0000010;
        tick();
        exp_note = 7'b0001000;
        tick();
        tick();
        chk_eq("pre_rst_hit", {30'd0, state}, S_HIT);
        #2 reset = 1'b0;
        #1;
        chk_eq("arst_state", {30'd0, state}, 0);
        chk_eq("arst_match", {31'd0, is_match}, 0);
        chk_eq("arst_score", {24'd0, score}, 0);
        model_reset();
        tick();
        reset = 1'b1;

        // Randomized traffic with occasional key bounces, enable drops and clears.
        for (int seg = 0; seg < 120; seg++) begin
            enable   = ($urandom_range(0, 9) != 0);
            exp_note = notes[$urandom_range(0, 3)];
            exp_high = 1'($urandom_range(0, 1));
            exp_low  = 1'($urandom_range(0, 1));
            keys     = ($urandom_range(0, 1) == 1) ? exp_note : notes[$urandom_range(0, 3)];
            oct_up   = ($urandom_range(0, 9) < 7) ? exp_high : 1'($urandom_range(0, 1));
            oct_down = ($urandom_range(0, 9) < 7) ? exp_low : 1'($urandom_range(0, 1));
            clear_score = ($urandom_range(0, 15) == 0);
            len = $urandom_range(1, 60);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 7) == 0) keys[$urandom_range(0, 6)] ^= 1'b1;
                tick();
                clear_score = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_match_checker.md
KEY_MATCH_CHECKER -- requirements
Module: key_match_checker

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20, giving the consecutive stable cycles needed to accept a key level.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the cycles allowed in WAIT before a miss.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: learn mode active.
REQ-006 The block SHALL have port clear_score, input, 1 bit: synchronous pulse that clears the score and miss counters.
REQ-007 The block SHALL have port exp_note, input, 7 bits: one-hot expected note from the player (do=bit6 … si=bit0); all-zero means rest.
REQ-008 The block SHALL have ports exp_high and exp_low, input, 1 bit each: octave of the expected note.
REQ-009 The block SHALL have port keys, input, 7 bits: raw asynchronous note keys, same bit order as exp_note.
REQ-010 The block SHALL have ports oct_up and oct_down, input, 1 bit each: raw octave switches.
REQ-011 The block SHALL have port is_match, output, 1 bit, registered: player may advance.
REQ-012 The block SHALL have port score, output, 8 bits: count of notes hit.
REQ-013 The block SHALL have port miss_cnt, output, 8 bits: count of timeouts.
REQ-014 The block SHALL have port state, output, 2 bits: IDLE=0, WAIT=1, HIT=2, MISS=3.

Function
REQ-015 keys, oct_up and oct_down SHALL each pass through a 2-flop synchronizer before any other use.
REQ-016 Debounce: each synchronized input SHALL have its own debounced value, updated only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that input's count.
REQ-017 Match condition SHALL be true when the debounced keys equal exp_note, debounced oct_up equals exp_high, and debounced oct_down equals exp_low.
REQ-018 For exp_note=0 (rest), the match condition SHALL therefore require all keys released and the octave switches equal to exp_high and exp_low.
REQ-019 Note change SHALL be true when {exp_note, exp_high, exp_low} differs from its value registered on the previous cycle.
REQ-020 When enable=0, the FSM SHALL go to IDLE on the next edge from any state, hold is_match=0, and retain score and miss_cnt.
REQ-021 IDLE->WAIT SHALL occur on the first cycle enable=1, with the timeout counter cleared and the scored flag cleared.
REQ-022 In WAIT, the timeout counter SHALL increment each cycle; on the match condition the FSM SHALL go to HIT and is_match SHALL be 1 from the next cycle.
REQ-023 On WAIT->HIT, score SHALL increment only if the scored flag is clear, after which the scored flag is set, so each note scores at most once.
REQ-024 In WAIT, when the timeout counter reaches TIMEOUT_CYCLES-1 without a match, the FSM SHALL go to MISS, miss_cnt SHALL increment, and the scored flag SHALL be set.
REQ-025 In MISS, is_match SHALL be 0; on the match condition the FSM SHALL go to HIT with no score increment, since the upstream player stalls until is_match=1.
REQ-026 In HIT, is_match SHALL be 1; if the match condition is lost without a note change, the FSM SHALL go to WAIT with the timeout counter cleared and the scored flag kept.
REQ-027 On a note change in WAIT, HIT or MISS, the FSM SHALL go to WAIT with the timer and scored flag cleared and is_match=0.
REQ-028 A note change SHALL have priority over a match or timeout in the same cycle.
REQ-029 score and miss_cnt SHALL saturate at 255.
REQ-030 clear_score SHALL zero score and miss_cnt on the next edge, with priority over a same-cycle increment, and SHALL not affect the FSM.
REQ-031 Latency SHALL be at most 2+DEBOUNCE_CYCLES+1 cycles from a stable key press to is_match=1.

Reset
REQ-032 When reset=0, the block SHALL asynchronously clear the synchronizers, debounced values, debounce counters, timeout counter, scored flag and registered note; set state=IDLE, is_match=0, score=0 and miss_cnt=0; and hold these values until reset=1.
REQ-033 A reset asserted mid-operation SHALL abort the current note with no counter update.

Verification
REQ-034 enable=1, exp_note=0000100, keys=0000100 held stable -> is_match=1 and score=1 exactly 2+20+1 cycles after the press; no further increment while held.
REQ-035 Key bounces every 5 cycles for 60 cycles and then holds stable -> is_match stays 0 until 20 stable cycles have elapsed.
REQ-036 No key pressed for 1000 cycles -> state=MISS and miss_cnt=1; a later correct press gives is_match=1 with score unchanged.
REQ-037 Correct key plus exp_high=1 but oct_up=0 -> no match; setting oct_up=1 -> is_match=1 after debounce.
REQ-038 score=255 plus another hit -> score stays 255; clear_score coincident with a hit -> score=0.
REQ-039 reset pulsed low while in HIT -> state=0, is_match=0, score=0 immediately, without waiting for a clock edge.
